alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  EX-stage datapath downstream of the ALU control decoder. Consumes the 4-bit ALU control code
//  plus two operands and a destination register tag, and computes result, zero and overflow.
//  Registers the outcome into a 2-entry output buffer (main + skid) with valid/ready handshakes
//  on both sides: throughput 1 op/cycle, 1-cycle latency. Feeds the EX/MEM boundary.
// PARAMETERS
//  WIDTH       32  operand/result width in bits
//  TAG_W        5  destination register tag width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      sync kill of all buffered ops (branch/exception)
//  in_valid   in   1      op presented
//  in_ready   out  1      stage can accept (registered)
//  alu_ctrl   in   4      ALU control code
//  op_a       in   WIDTH  operand A (rs)
//  op_b       in   WIDTH  operand B (rt/imm)
//  in_tag     in   TAG_W  destination register
//  out_valid  out  1      result presented
//  out_ready  in   1      consumer accepts
//  result     out  WIDTH  ALU result
//  zero       out  1      result == 0
//  ovf        out  1      signed overflow (add/sub only)
//  illegal    out  1      unsupported alu_ctrl code
//  out_tag    out  TAG_W  destination register of presented result
// BEHAVIOUR
//  Reset (async, rst_n=0): both entries invalid; out_valid=0, in_ready=1, result/out_tag=0, zero/ovf/illegal=0.
//  Codes: 0010 add; 0110 sub (a-b); 0000 and; 0001 or; 0111 slt (signed, result 1/0); 1100 nor.
//   Any other code (incl. 1110, 1111): result=0, zero=1, ovf=0, illegal=1; op still flows normally.
//  Add/sub are modulo 2^WIDTH; ovf = operand signs agree (b inverted for sub) and result sign differs.
//   ovf=0 for logic ops and slt; slt uses a true signed compare, unaffected by overflow.
//  zero is computed from the final result of every op.
//  Accept = in_valid & in_ready; fire = out_valid & out_ready. Storage: M (drives outputs), S (skid).
//  in_ready = !S.valid (registered from state, never combinational from out_ready).
//  Per-edge update, no flush:
//   fire & S.valid      -> M<=S, S empty (in_ready was 0, so no accept).
//   accept & (!M.valid | fire) -> M<=new op.
//   accept & M.valid & !fire   -> S<=new op; in_ready drops next cycle.
//   fire & !accept & !S.valid  -> M empty.
//  Latency: op accepted at edge k appears on outputs after edge k (out_valid in cycle k+1).
//  Outputs are held stable while out_valid=1 and out_ready=0; order is strictly FIFO.
//  flush=1: at the edge both entries are invalidated; any same-cycle accept is discarded.
//   After the edge out_valid=0 and in_ready=1. A same-cycle fire is still counted by the consumer.
//  Data fields of invalid entries are don't-care; out_valid is authoritative.
//  Async reset mid-stream drops all ops immediately, without waiting for a clock edge.
// TESTING
//  T1 add 5+7, tag 3, out_ready=1 -> next cycle out_valid=1, result=12, zero=0, ovf=0, out_tag=3.
//  T2 sub 0x10-0x10 -> result=0, zero=1; slt 0xFFFFFFFF,1 -> result=1; nor 0,0 -> 0xFFFFFFFF.
//  T3 add 0x7FFFFFFF+1 -> result=0x80000000, ovf=1; sub 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
//  T4 out_ready=0, push ops A,B,C back-to-back -> A,B accepted, in_ready=0 while C held;
//     release out_ready -> A,B,C drain in order with no loss or duplication.
//  T5 alu_ctrl=1110 and 1111 -> illegal=1, result=0, zero=1; next op 0010 -> illegal=0.
//  T6 flush with M,S full and in_valid=1 -> all dropped, out_valid=0, in_ready=1;
//     rst_n pulse mid-stream -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : EX-stage ALU with a main+skid output buffer and valid/ready
//            handshakes on both sides (1 op/cycle, 1-cycle latency).
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [3:0] c_and = 4'b0000;
  localparam logic [3:0] c_or  = 4'b0001;
  localparam logic [3:0] c_add = 4'b0010;
  localparam logic [3:0] c_sub = 4'b0110;
  localparam logic [3:0] c_slt = 4'b0111;
  localparam logic [3:0] c_nor = 4'b1100;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           new_entry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sign_a;
  logic             sign_b;

  assign sum    = op_a + op_b;
  assign diff   = op_a - op_b;
  assign sign_a = op_a[WIDTH-1];
  assign sign_b = op_b[WIDTH-1];

  always_comb begin
    new_entry         = '0;
    new_entry.tag     = in_tag;
    case (alu_ctrl)
      c_add: begin
        new_entry.result = sum;
        new_entry.ovf    = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
      end
      c_sub: begin
        new_entry.result = diff;
        new_entry.ovf    = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
      end
      c_and: new_entry.result = op_a & op_b;
      c_or:  new_entry.result = op_a | op_b;
      // Signed compare on the operands, not on diff, so overflow cannot flip it.
      c_slt: new_entry.result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      c_nor: new_entry.result = ~(op_a | op_b);
      default: new_entry.illegal = 1'b1;
    endcase
    new_entry.zero = (new_entry.result == '0);
  end

  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  entry_t m_data_q,  m_data_d;
  entry_t s_data_q,  s_data_d;
  logic   accept;
  logic   fire;

  assign in_ready = !s_valid_q;
  assign accept   = in_valid && in_ready;
  assign fire     = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (fire && s_valid_q) begin
      // Skid full implies in_ready was low, so no accept can coincide here.
      m_data_d  = s_data_q;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid_q || fire)) begin
      m_data_d  = new_entry;
      m_valid_d = 1'b1;
    end else if (accept) begin
      s_data_d  = new_entry;
      s_valid_d = 1'b1;
    end else if (fire) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign out_valid = m_valid_q;
  assign result    = m_data_q.result;
  assign zero      = m_data_q.zero;
  assign ovf       = m_data_q.ovf;
  assign illegal   = m_data_q.illegal;
  assign out_tag   = m_data_q.tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_stage
// Purpose  : Table-driven, scoreboarded bench for alu_exec_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;
  logic [4:0]  out_tag;

  alu_exec_stage #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .illegal(illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
    logic [4:0]  tag;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t cur_exp;
  bit   rand_ready = 1'b0;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: compare on fire first, then record the op accepted this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got result=0x%08h tag=%0d expected none", result, out_tag);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (result !== e.res || zero !== e.z || ovf !== e.o || illegal !== e.il || out_tag !== e.tag) begin
            errors++;
            $display("FAIL output: got res=0x%08h z=%b o=%b il=%b tag=%0d expected res=0x%08h z=%b o=%b il=%b tag=%0d",
                     result, zero, ovf, illegal, out_tag, e.res, e.z, e.o, e.il, e.tag);
          end
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic set_in(input vec_t v, input logic [4:0] tag);
    in_valid = 1'b1;
    alu_ctrl = v.ctrl;
    op_a     = v.a;
    op_b     = v.b;
    in_tag   = tag;
    cur_exp  = '{v.res, v.z, v.o, v.il, tag};
  endtask

  task automatic wait_accept();
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drive(input vec_t v, input logic [4:0] tag);
    set_in(v, tag);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    vec_t va, vb, vc;
    vecs[0]  = '{4'b0010, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 32'h10,        32'h10,        32'd0,         1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'b0111, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b1100, 32'd0,         32'd0,         32'hFFFFFFFF,  1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0010, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'b0110, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'b0000, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0001, 32'h0F0F0000,  32'h000000F0,  32'h0F0F00F0,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'b1110, 32'h12345678,  32'h9ABCDEF0,  32'd0,         1'b1, 1'b0, 1'b1};
    vecs[9]  = '{4'b1111, 32'd123,       32'd456,       32'd0,         1'b1, 1'b0, 1'b1};
    vecs[10] = '{4'b0010, 32'd1,         32'd2,         32'd3,         1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b0111, 32'd1,         32'hFFFFFFFF,  32'd0,         1'b1, 1'b0, 1'b0};
    vecs[12] = '{4'b0111, 32'h80000000,  32'h7FFFFFFF,  32'd1,         1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'b0010, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'b0110, 32'h7FFFFFFF,  32'hFFFFFFFF,  32'h80000000,  1'b0, 1'b1, 1'b0};
    vecs[15] = '{4'b0000, 32'h80000000,  32'h80000000,  32'h80000000,  1'b0, 1'b0, 1'b0};
    vecs[16] = '{4'b0011, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         1'b1, 1'b0, 1'b1};

    // Reset values
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_result",    result,         32'd0);
    check("rst_flags",     {29'd0, zero, ovf, illegal}, 32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First op: one-cycle latency
    drive(vecs[0], 5'd3);
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    check("t1_result",        result,         32'd12);
    check("t1_tag",           32'(out_tag),   32'd3);

    // Back-to-back table with out_ready held high
    for (int i = 1; i < 17; i++) drive(vecs[i], 5'(i + 3));
    drain();

    // Same table with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 17; i++) drive(vecs[i], 5'(i + 8));
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    // Skid: A,B accepted under backpressure, C stalls, then all drain in order
    va = vecs[0]; vb = vecs[3]; vc = vecs[6];
    out_ready = 1'b0;
    drive(va, 5'd21);
    drive(vb, 5'd22);
    check("skid_in_ready_low", 32'(in_ready), 32'd0);
    set_in(vc, 5'd23);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("skid_hold_valid",  32'(out_valid), 32'd1);
    check("skid_hold_result", result,         32'd12);
    check("skid_hold_tag",    32'(out_tag),   32'd21);
    check("skid_still_full",  32'(in_ready),  32'd0);
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Flush with both entries full and an op presented
    out_ready = 1'b0;
    drive(va, 5'd24);
    drive(vb, 5'd25);
    set_in(vc, 5'd26);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_full_out_valid", 32'(out_valid), 32'd0);
    check("flush_full_in_ready",  32'(in_ready),  32'd1);

    // Flush with a same-cycle accept: the new op must be discarded
    drive(va, 5'd27);
    set_in(vb, 5'd28);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_accept_out_valid", 32'(out_valid), 32'd0);
    check("flush_accept_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("flush_stays_empty", 32'(out_valid), 32'd0);

    // Async reset mid-stream, checked before the next clock edge
    out_ready = 1'b0;
    drive(va, 5'd29);
    drive(vb, 5'd30);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    check("async_rst_result",    result,         32'd0);
    check("async_rst_tag",       32'(out_tag),   32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    drive(vecs[14], 5'd31);
    check("post_rst_result", result, 32'h80000000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
